// File: rtl/priority_cmd_seq.sv
// Command sequencer feeding the priority FSM: queues {len, sel} commands and
// replays each as a do-burst followed by a held sel code. Optional statistics via PRIO_SEQ_STATS_EN.
module priority_cmd_seq #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [1:0]       cmd_sel,
    output logic             fsm_do,
    output logic [1:0]       fsm_sel,
    input  logic             fsm_f,
    output logic             busy,
    output logic             err_timeout,
    input  logic             err_clr
`ifdef PRIO_SEQ_STATS_EN
    ,
    output logic [15:0]      cmd_cnt,
    output logic [15:0]      f_cnt
`endif
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = LEN_W + 2;
    localparam int WMAX    = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int WCNT_W  = (WMAX > 1) ? $clog2(WMAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               full, empty, push, pop;
    logic [LEN_W-1:0]   head_len;
    logic [1:0]         head_sel;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    // Push is gated by the registered full flag only, so a same-cycle pop never opens a slot.
    assign push      = cmd_valid && !full;
    assign cmd_ready = !full;
    assign head_len  = mem[rd_ptr_reg][ENTRY_W-1:2];
    assign head_sel  = mem[rd_ptr_reg][1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cmd_len, cmd_sel};
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Replay FSM
    // ------------------------------------------------------------------
    state_t            state_reg, state_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
    logic              do_reg, do_next;
    logic [1:0]        sel_reg, sel_next;
    logic              err_reg, err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            wcnt_reg  <= '0;
            do_reg    <= 1'b0;
            sel_reg   <= 2'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            wcnt_reg  <= wcnt_next;
            do_reg    <= do_next;
            sel_reg   <= sel_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        wcnt_next  = wcnt_reg;
        do_next    = do_reg;
        sel_next   = sel_reg;
        err_next   = err_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    len_next   = (head_len == '0) ? LEN_W'(1) : head_len;
                    do_next    = 1'b1;
                    sel_next   = head_sel;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                // len_reg counts the do cycles still to be presented, including this one.
                if (len_reg <= LEN_W'(1)) begin
                    do_next    = 1'b0;
                    wcnt_next  = '0;
                    state_next = WAIT;
                end else begin
                    len_next = len_reg - LEN_W'(1);
                end
            end
            WAIT: begin
                wcnt_next = wcnt_reg + WCNT_W'(1);
                if (sel_reg == 2'd3) begin
                    if (fsm_f) begin
                        state_next = IDLE;
                    end else if (wcnt_reg == WCNT_W'(TIMEOUT - 1)) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else if (wcnt_reg == WCNT_W'(SETTLE - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                do_next    = 1'b0;
                state_next = IDLE;
            end
        endcase
        if (err_clr) begin
            err_next = 1'b0;
        end
    end

    assign fsm_do      = do_reg;
    assign fsm_sel     = sel_reg;
    assign err_timeout = err_reg;
    assign busy        = (state_reg != IDLE) || !empty;

`ifdef PRIO_SEQ_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics, cleared together with the timeout flag
    // ------------------------------------------------------------------
    logic        f_accept;
    logic [15:0] cmd_cnt_reg, f_cnt_reg;

    assign f_accept = (state_reg == WAIT) && (sel_reg == 2'd3) && fsm_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_cnt_reg <= '0;
            f_cnt_reg   <= '0;
        end else if (err_clr) begin
            cmd_cnt_reg <= '0;
            f_cnt_reg   <= '0;
        end else begin
            if (pop && cmd_cnt_reg != 16'hFFFF)    cmd_cnt_reg <= cmd_cnt_reg + 16'd1;
            if (f_accept && f_cnt_reg != 16'hFFFF) f_cnt_reg   <= f_cnt_reg + 16'd1;
        end
    end

    assign cmd_cnt = cmd_cnt_reg;
    assign f_cnt   = f_cnt_reg;
`endif

endmodule

// File: tb/tb_priority_cmd_seq.sv
// Directed bench for priority_cmd_seq; statistics checks are active when PRIO_SEQ_STATS_EN is defined.
module tb_priority_cmd_seq;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [1:0]       cmd_sel;
    logic             fsm_do;
    logic [1:0]       fsm_sel;
    logic             fsm_f;
    logic             busy;
    logic             err_timeout;
    logic             err_clr;
`ifdef PRIO_SEQ_STATS_EN
    logic [15:0]      cmd_cnt;
    logic [15:0]      f_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    priority_cmd_seq #(
        .DEPTH  (4),
        .LEN_W  (LEN_W),
        .SETTLE (2),
        .TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_sel    (cmd_sel),
        .fsm_do     (fsm_do),
        .fsm_sel    (fsm_sel),
        .fsm_f      (fsm_f),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_clr    (err_clr)
`ifdef PRIO_SEQ_STATS_EN
        ,
        .cmd_cnt    (cmd_cnt),
        .f_cnt      (f_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Burst recorder: length of each do run and the sel held when it ends.
    int run_len = 0;
    int burst_len[$];
    int burst_sel[$];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len <= 0;
        end else if (fsm_do) begin
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            burst_len.push_back(run_len);
            burst_sel.push_back(int'(fsm_sel));
            run_len <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input int len, input int sel);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_len   = len[LEN_W-1:0];
        cmd_sel   = sel[1:0];
        while (!cmd_ready && waited < 200) begin
            tick();
            waited++;
        end
        check("push_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic serve_f();
        int n = 0;
        while (!fsm_do && n < 50) begin
            tick();
            n++;
        end
        check("serve_do_rise", 32'(fsm_do), 32'd1);
        n = 0;
        while (fsm_do && n < 50) begin
            tick();
            n++;
        end
        check("serve_do_fall", 32'(fsm_do), 32'd0);
        tick();
        tick();
        fsm_f = 1'b1;
        tick();
        fsm_f = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int exp_len[6];
        int exp_sel[6];
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_sel   = '0;
        fsm_f     = 1'b0;
        err_clr   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_do",    32'(fsm_do),      32'd0);
        check("rst_sel",   32'(fsm_sel),     32'd0);
        check("rst_err",   32'(err_timeout), 32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_ready", 32'(cmd_ready),   32'd1);
        rst_n = 1'b1;
        tick();

        // 1: len=3 sel=3, f on the 3rd cycle after do falls
        push_cmd(3, 3);
        check("t1_busy_queued", 32'(busy),   32'd1);
        check("t1_no_same_pop", 32'(fsm_do), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t1_do_hi", 32'(fsm_do),  32'd1);
            check("t1_sel",   32'(fsm_sel), 32'd3);
            tick();
        end
        check("t1_do_fall", 32'(fsm_do), 32'd0);
        tick();
        tick();
        check("t1_busy_wait", 32'(busy), 32'd1);
        fsm_f = 1'b1;
        tick();
        fsm_f = 1'b0;
        check("t1_busy_done", 32'(busy),        32'd0);
        check("t1_err",       32'(err_timeout), 32'd0);
        check("t1_sel_held",  32'(fsm_sel),     32'd3);

        // 2: len=0 sel=2 -> single do cycle, 2 settle cycles
        push_cmd(0, 2);
        tick();
        check("t2_do_hi", 32'(fsm_do),  32'd1);
        check("t2_sel",   32'(fsm_sel), 32'd2);
        tick();
        check("t2_do_lo",   32'(fsm_do), 32'd0);
        check("t2_busy_w0", 32'(busy),   32'd1);
        tick();
        check("t2_busy_w1", 32'(busy),   32'd1);
        tick();
        check("t2_busy_done", 32'(busy),        32'd0);
        check("t2_err",       32'(err_timeout), 32'd0);

        // 3: len=2 sel=3 with f tied low -> timeout after 8 WAIT cycles
        push_cmd(2, 3);
        tick();
        tick();
        tick();
        check("t3_do_lo", 32'(fsm_do), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("t3_err_pending", 32'(err_timeout), 32'd0);
        end
        tick();
        check("t3_err_set",  32'(err_timeout), 32'd1);
        check("t3_busy",     32'(busy),        32'd0);
        tick();
        check("t3_err_stick", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_err_clr", 32'(err_timeout), 32'd0);

        // 4: six back-to-back commands, FIFO fills behind a long first burst
        burst_len.delete();
        burst_sel.delete();
        exp_len = '{15, 1, 2, 3, 4, 5};
        exp_sel = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 5; i++) begin
            push_cmd(exp_len[i], exp_sel[i]);
        end
        check("t4_ready_full", 32'(cmd_ready), 32'd0);
        tick();
        tick();
        check("t4_ready_still_full", 32'(cmd_ready), 32'd0);
        push_cmd(exp_len[5], exp_sel[5]);
        wait_idle("t4_drain");
        tick();
        check("t4_nbursts", 32'(burst_len.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("t4_burst_len", 32'((i < burst_len.size()) ? burst_len[i] : -1), 32'(exp_len[i]));
            check("t4_burst_sel", 32'((i < burst_sel.size()) ? burst_sel[i] : -1), 32'(exp_sel[i]));
        end

        // 5: reset during a len=15 burst with another command queued
        push_cmd(15, 1);
        tick();
        push_cmd(2, 2);
        tick();
        tick();
        check("t5_do_pre", 32'(fsm_do), 32'd1);
        check("t5_busy_pre", 32'(busy), 32'd1);
        burst_len.delete();
        burst_sel.delete();
        rst_n = 1'b0;
        #1;
        check("t5_do_rst",   32'(fsm_do),  32'd0);
        check("t5_sel_rst",  32'(fsm_sel), 32'd0);
        check("t5_busy_rst", 32'(busy),    32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_residual_do", 32'(fsm_do), 32'd0);
        check("t5_no_bursts", 32'(burst_len.size()), 32'd0);
        check("t5_busy_after", 32'(busy), 32'd0);

        // 6: three sel=3 commands served by f
`ifdef PRIO_SEQ_STATS_EN
        check("t6_cmd_cnt0", 32'(cmd_cnt), 32'd0);
        check("t6_f_cnt0",   32'(f_cnt),   32'd0);
`endif
        for (int i = 1; i <= 3; i++) begin
            push_cmd(i, 3);
            serve_f();
            check("t6_idle", 32'(busy), 32'd0);
        end
        check("t6_err", 32'(err_timeout), 32'd0);
        check("t6_nbursts", 32'(burst_len.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("t6_burst_len", 32'((i < burst_len.size()) ? burst_len[i] : -1), 32'(i + 1));
        end
        // Stray f while idle must be ignored
        fsm_f = 1'b1;
        tick();
        fsm_f = 1'b0;
        tick();
        check("t6_stray_busy", 32'(busy),        32'd0);
        check("t6_stray_err",  32'(err_timeout), 32'd0);
`ifdef PRIO_SEQ_STATS_EN
        check("t6_cmd_cnt3", 32'(cmd_cnt), 32'd3);
        check("t6_f_cnt3",   32'(f_cnt),   32'd3);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t6_cmd_cnt_clr", 32'(cmd_cnt), 32'd0);
        check("t6_f_cnt_clr",   32'(f_cnt),   32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
